hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: memory-wait stall, branch flush and load-use bubble, plus operand forwarding.
// Stall/flush decisions are combinational; a 3-state FSM sequences multi-cycle stalls; counters saturate.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        rs1_need,
  input  logic        rs2_need,
  input  logic [4:0]  rd_e,
  input  logic        reg_we_e,
  input  logic [1:0]  wb_ctr_e,
  input  logic [4:0]  rd_m,
  input  logic        reg_we_m,
  input  logic [4:0]  rd_w,
  input  logic        reg_we_w,
  input  logic        branch_taken_e,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        en_f,
  output logic        en_d,
  output logic        en_e,
  output logic        en_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] S_RUN       = 2'b00;
  localparam logic [1:0] S_LU_BUBBLE = 2'b01;
  localparam logic [1:0] S_MEM_WAIT  = 2'b10;

  logic [1:0] state_nxt;
  logic       mem_stall;
  logic       load_use;

  // Once in MEM_WAIT the stall persists until ack, whether or not the request is still shown.
  assign mem_stall = !dmem_ack && (dmem_req || (state == S_MEM_WAIT));

  assign load_use = reg_we_e && (wb_ctr_e == 2'b01) && (rd_e != 5'd0) &&
                    ((rs1_need && (rs1_d == rd_e)) || (rs2_need && (rs2_d == rd_e)));

  always_comb begin
    en_f      = 1'b1;
    en_d      = 1'b1;
    en_e      = 1'b1;
    en_m      = 1'b1;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    state_nxt = S_RUN;
    if (!rst) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      en_m    = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mem_stall) begin
      en_f      = 1'b0;
      en_d      = 1'b0;
      en_e      = 1'b0;
      en_m      = 1'b0;
      state_nxt = S_MEM_WAIT;
    end else if (branch_taken_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use && (state == S_RUN)) begin
      en_f      = 1'b0;
      en_d      = 1'b0;
      flush_e   = 1'b1;
      state_nxt = S_LU_BUBBLE;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (rs == 5'd0)                 return 2'b00;
    else if (m_we && (m_rd == rs))  return 2'b01;
    else if (w_we && (w_rd == rs))  return 2'b10;
    else                            return 2'b00;
  endfunction

  assign fwd_a = rst ? fwd_sel(rs1_d, rd_m, reg_we_m, rd_w, reg_we_w) : 2'b00;
  assign fwd_b = rst ? fwd_sel(rs2_d, rd_m, reg_we_m, rd_w, reg_we_w) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (!en_d && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_d && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle reference model comparison plus hand-computed literal checks.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rd_e, rd_m, rd_w;
  logic        rs1_need, rs2_need, reg_we_e, reg_we_m, reg_we_w;
  logic [1:0]  wb_ctr_e;
  logic        branch_taken_e, dmem_req, dmem_ack;
  logic        en_f, en_d, en_e, en_m, flush_d, flush_e;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_need(rs1_need), .rs2_need(rs2_need),
    .rd_e(rd_e), .reg_we_e(reg_we_e), .wb_ctr_e(wb_ctr_e),
    .rd_m(rd_m), .reg_we_m(reg_we_m), .rd_w(rd_w), .reg_we_w(reg_we_w),
    .branch_taken_e(branch_taken_e), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: "waiting on memory" and "bubble owed" flags plus plain integer counters.
  bit m_waiting = 1'b0;
  bit m_bubble  = 1'b0;
  int m_stalls  = 0;
  int m_flushes = 0;

  function automatic logic [1:0] src_of(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (reg_we_m && rd_m == rs) return 2'b01;
    if (reg_we_w && rd_w == rs) return 2'b10;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [3:0] x_en;
    logic [1:0] x_fl, x_st;
    bit frozen, hazard;
    x_st   = m_waiting ? 2'b10 : (m_bubble ? 2'b01 : 2'b00);
    frozen = (dmem_req || m_waiting) && !dmem_ack;
    hazard = reg_we_e && wb_ctr_e == 2'b01 && rd_e != 0 &&
             ((rs1_need && rs1_d == rd_e) || (rs2_need && rs2_d == rd_e));
    chk("state", state, x_st);
    chk("stall_cnt", stall_cnt, m_stalls[15:0]);
    chk("flush_cnt", flush_cnt, m_flushes[15:0]);
    if (!rst) begin
      chk("en", {en_f, en_d, en_e, en_m}, 4'b0000);
      chk("flush", {flush_d, flush_e}, 2'b11);
      chk("fwd", {fwd_a, fwd_b}, 4'b0000);
      m_waiting = 0; m_bubble = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (frozen) begin
        x_en = 4'b0000; x_fl = 2'b00;
      end else if (branch_taken_e) begin
        x_en = 4'b1111; x_fl = 2'b11;
      end else if (hazard && !m_waiting && !m_bubble) begin
        x_en = 4'b0011; x_fl = 2'b01;
      end else begin
        x_en = 4'b1111; x_fl = 2'b00;
      end
      chk("en", {en_f, en_d, en_e, en_m}, x_en);
      chk("flush", {flush_d, flush_e}, x_fl);
      chk("fwd", {fwd_a, fwd_b}, {src_of(rs1_d), src_of(rs2_d)});
      m_bubble  = !frozen && !branch_taken_e && hazard && !m_waiting && !m_bubble;
      m_waiting = frozen;
      if (x_en[2] == 1'b0 && m_stalls < 65535) m_stalls++;
      if (x_fl[1] && m_flushes < 65535) m_flushes++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; rs1_d = 0; rs2_d = 0; rs1_need = 0; rs2_need = 0;
    rd_e = 0; reg_we_e = 0; wb_ctr_e = 0; rd_m = 0; reg_we_m = 0;
    rd_w = 0; reg_we_w = 0; branch_taken_e = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic do_rst();
    idle();
    rst = 1'b0;
    nxt();
    rst = 1'b1;
  endtask

  task automatic load_use_inputs();
    rd_e = 5'd5; reg_we_e = 1'b1; wb_ctr_e = 2'b01; rs1_d = 5'd5; rs1_need = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    rs1_d = 5'd3; rd_m = 5'd3; reg_we_m = 1'b1;
    nxt();
    @(negedge clk);
    chk("rst_state", state, 2'b00);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_en_d", en_d, 1'b0);
    chk("rst_flush_e", flush_e, 1'b1);
    chk("rst_fwd_a", fwd_a, 2'b00);
    nxt();
    idle();
    @(negedge clk);
    chk("run_en_f", en_f, 1'b1);

    // Load-use stall: one bubble cycle, hazard inputs held but ignored in the bubble.
    do_rst();
    load_use_inputs();
    @(negedge clk);
    chk("lu_en_d", en_d, 1'b0);
    chk("lu_flush_e", flush_e, 1'b1);
    nxt();
    @(negedge clk);
    chk("lu_state_bubble", state, 2'b01);
    chk("lu_bubble_en_d", en_d, 1'b1);
    nxt();
    idle();
    @(negedge clk);
    chk("lu_state_back", state, 2'b00);
    chk("lu_stall_cnt", stall_cnt, 16'd1);

    // Branch overrides load-use.
    do_rst();
    load_use_inputs();
    branch_taken_e = 1'b1;
    @(negedge clk);
    chk("br_en_d", en_d, 1'b1);
    chk("br_flush_d", flush_d, 1'b1);
    nxt();
    idle();
    @(negedge clk);
    chk("br_state", state, 2'b00);
    chk("br_flush_cnt", flush_cnt, 16'd1);
    chk("br_stall_cnt", stall_cnt, 16'd0);

    // Memory wait of 3 cycles with a branch pending; branch acts on the ack cycle.
    do_rst();
    dmem_req = 1'b1;
    branch_taken_e = 1'b1;
    @(negedge clk);
    chk("mw_en_m", en_m, 1'b0);
    chk("mw_flush_d_frozen", flush_d, 1'b0);
    nxt();
    dmem_req = 1'b0;
    @(negedge clk);
    chk("mw_state", state, 2'b10);
    nxt();
    nxt();
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("mw_ack_en_d", en_d, 1'b1);
    chk("mw_ack_flush_d", flush_d, 1'b1);
    nxt();
    idle();
    @(negedge clk);
    chk("mw_state_back", state, 2'b00);
    chk("mw_stall_cnt", stall_cnt, 16'd3);
    chk("mw_flush_cnt", flush_cnt, 16'd1);

    // Same-cycle req+ack, then load-use hitting a memory stall in the bubble.
    dmem_req = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    chk("reqack_en_d", en_d, 1'b1);
    nxt();
    idle();
    load_use_inputs();
    nxt();
    dmem_req = 1'b1;
    nxt();
    idle();
    @(negedge clk);
    chk("lu_then_mw_state", state, 2'b10);
    dmem_ack = 1'b1;
    nxt();
    idle();

    // Forwarding priority and register zero.
    rs2_d = 5'd7; rd_m = 5'd7; reg_we_m = 1'b1; rd_w = 5'd7; reg_we_w = 1'b1;
    @(negedge clk);
    chk("fwd_b_mem", fwd_b, 2'b01);
    nxt();
    reg_we_m = 1'b0; rs1_d = 5'd7;
    @(negedge clk);
    chk("fwd_b_wb", fwd_b, 2'b10);
    chk("fwd_a_wb", fwd_a, 2'b10);
    nxt();
    rs2_d = 5'd0; rd_w = 5'd0; rd_m = 5'd0; reg_we_m = 1'b1;
    @(negedge clk);
    chk("fwd_b_zero", fwd_b, 2'b00);
    nxt();

    // Non-hazards: rd_e=0, unused rs2, non-load writeback.
    idle();
    rd_e = 0; reg_we_e = 1; wb_ctr_e = 2'b01; rs1_d = 0; rs1_need = 1;
    @(negedge clk);
    chk("zero_reg_no_stall", en_d, 1'b1);
    nxt();
    rd_e = 5'd9; rs2_d = 5'd9; rs2_need = 1'b0; rs1_d = 5'd1;
    nxt();
    rs2_need = 1'b1; wb_ctr_e = 2'b10;
    @(negedge clk);
    chk("alu_no_stall", en_d, 1'b1);
    nxt();

    // Reset abandons a bubble and a memory wait.
    idle();
    load_use_inputs();
    nxt();
    rst = 1'b0;
    nxt();
    idle();
    @(negedge clk);
    chk("rst_bubble_state", state, 2'b00);
    chk("rst_bubble_en_d", en_d, 1'b1);
    dmem_req = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    nxt();
    idle();
    @(negedge clk);
    chk("rst_mw_state", state, 2'b00);
    chk("rst_mw_stall_cnt", stall_cnt, 16'd0);
    chk("rst_mw_en_m", en_m, 1'b1);

    // Long memory wait saturates the stall counter.
    do_rst();
    dmem_req = 1'b1;
    repeat (65540) nxt();
    @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    dmem_ack = 1'b1;
    nxt();
    idle();
    @(negedge clk);
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_state", state, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
